sram_frame_loader: RTL and testbench

//  Upstream stage of the matcher top level. On a start request, streams one eye

---
 rtl/sram_frame_loader_pkg.sv | 12 +
 rtl/sram_frame_loader_if.sv | 33 +++
 rtl/sram_frame_loader_read_timer.sv | 31 +++
 rtl/sram_frame_loader.sv | 127 ++++++++++++
 tb/tb_sram_frame_loader.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/sram_frame_loader_pkg.sv
// Shared definitions for the SRAM frame loader: FSM encoding and SRAM/pixel widths.
package sram_loader_pkg;
  localparam int SRAM_AW = 20;
  localparam int SRAM_DW = 16;
  localparam int PIX_W   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/sram_frame_loader_if.sv
// SRAM read port plus the paired match-buffer write port driven by the loader.
interface sram_frame_loader_if
  import sram_loader_pkg::*;
#(
  parameter int BUF_AW = 15
);
  logic               CE_n;
  logic               OE_n;
  logic               WE_n;
  logic               UB_n;
  logic               LB_n;
  logic [SRAM_AW-1:0] addr;
  logic [SRAM_DW-1:0] IO;
  // Buffer writes have no back-pressure: a word is committed on every cycle w_en_a is high.
  logic               w_en_a;
  logic               w_en_b;
  logic [BUF_AW-1:0]  addr_a;
  logic [BUF_AW-1:0]  addr_b;
  logic [PIX_W-1:0]   data_a;
  logic [PIX_W-1:0]   data_b;

  modport master (
    output CE_n, OE_n, WE_n, UB_n, LB_n, addr,
    input  IO,
    output w_en_a, w_en_b, addr_a, addr_b, data_a, data_b
  );

  modport slave (
    input  CE_n, OE_n, WE_n, UB_n, LB_n, addr,
    output IO,
    input  w_en_a, w_en_b, addr_a, addr_b, data_a, data_b
  );
endinterface

// File: rtl/sram_frame_loader_read_timer.sv
// Per-word SRAM access timer: counts 0..RD_WAIT while the SRAM is enabled.
module sram_read_timer #(
  parameter int RD_WAIT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic en,
  input  logic last,
  output logic sample,
  output logic next_word
);
  localparam int CW = (RD_WAIT < 1) ? 1 : $clog2(RD_WAIT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(RD_WAIT);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
    end
  end

  // IO is captured on the final hold cycle; the address advances on the same edge.
  assign sample    = en & (cnt == CNT_MAX);
  assign next_word = sample & ~last;
endmodule

// File: rtl/sram_frame_loader.sv
// Streams one frame of SRAM words into the two match-buffer banks on a start falling edge.
// Optional build macro CHECKSUM_EN adds a modulo-2**16 word checksum output.
module sram_frame_loader
  import sram_loader_pkg::*;
#(
  parameter int WORDS     = 13504,
  parameter int BASE_ADDR = 0,
  parameter int RD_WAIT   = 2,
  parameter int BUF_AW    = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  sram_frame_loader_if.master        bus,
  output logic                       busy,
  output logic                       load_done,
`ifdef CHECKSUM_EN
  output logic [SRAM_DW-1:0]         checksum,
`endif
  output state_t                     state_dbg
);
  localparam logic [BUF_AW-1:0] LAST_K = BUF_AW'(WORDS - 1);

  state_t             state, state_next;
  logic               start_d;
  logic               trig, accept, finish, last;
  logic               primed, run;
  logic               sample, next_word;
  logic               w_en;
  logic [BUF_AW-1:0]  k, wr_idx;
  logic [SRAM_DW-1:0] io_q;

  assign trig   = start_d & ~start;
  assign accept = trig & (state != READ);
  assign last   = (k == LAST_K);
  assign finish = (state == READ) & w_en & (wr_idx == LAST_K);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) start_d <= 1'b1;
    else      start_d <= start;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, DONE: if (trig)   state_next = READ;
      READ:       if (finish) state_next = DONE;
      default:                state_next = IDLE;
    endcase
  end

  // primed delays SRAM enable by one cycle after the trigger edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      primed    <= 1'b0;
      run       <= 1'b0;
      k         <= '0;
      wr_idx    <= '0;
      io_q      <= '0;
      w_en      <= 1'b0;
      busy      <= 1'b0;
      load_done <= 1'b0;
    end else begin
      w_en <= 1'b0;
      if (accept) begin
        primed    <= 1'b1;
        run       <= 1'b0;
        k         <= '0;
        busy      <= 1'b1;
        load_done <= 1'b0;
      end else begin
        if (primed) begin
          primed <= 1'b0;
          run    <= 1'b1;
        end
        if (sample) begin
          io_q   <= bus.IO;
          w_en   <= 1'b1;
          wr_idx <= k;
          if (last) run <= 1'b0;
        end
        if (next_word) k <= k + 1'b1;
        if (finish) begin
          busy      <= 1'b0;
          load_done <= 1'b1;
        end
      end
    end
  end

`ifdef CHECKSUM_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        checksum <= '0;
    else if (accept) checksum <= '0;
    else if (sample) checksum <= checksum + bus.IO;
  end
`endif

  sram_read_timer #(.RD_WAIT(RD_WAIT)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .restart   (accept),
    .en        (run),
    .last      (last),
    .sample    (sample),
    .next_word (next_word)
  );

  assign bus.CE_n   = ~run;
  assign bus.OE_n   = ~run;
  assign bus.UB_n   = ~run;
  assign bus.LB_n   = ~run;
  assign bus.WE_n   = 1'b1;
  assign bus.addr   = SRAM_AW'(BASE_ADDR) + SRAM_AW'(k);
  assign bus.w_en_a = w_en;
  assign bus.w_en_b = w_en;
  assign bus.addr_a = wr_idx;
  assign bus.addr_b = wr_idx;
  assign bus.data_a = io_q[PIX_W-1:0];
  assign bus.data_b = io_q[SRAM_DW-1:PIX_W];
  assign state_dbg  = state;
endmodule

// File: tb/tb_sram_frame_loader.sv
// Directed bench for sram_frame_loader: 4-word frames, RD_WAIT=2, IO = 16'hA0B0 + addr.
module tb_sram_frame_loader;
  import sram_loader_pkg::*;

  localparam int WORDS     = 4;
  localparam int BASE_ADDR = 0;
  localparam int RD_WAIT   = 2;
  localparam int BUF_AW    = 15;
  localparam int P         = RD_WAIT + 1;
  localparam int EW        = BUF_AW + 16;

  typedef struct {
    int                cyc;
    logic [BUF_AW-1:0] a;
    logic [7:0]        da;
    logic [7:0]        db;
  } strobe_t;

  // clock / reset
  logic   clk   = 1'b0;
  logic   rst   = 1'b0;
  logic   start = 1'b1;
  logic   busy, load_done;
  state_t state_dbg;
  logic   ck_mode = 1'b0;
`ifdef CHECKSUM_EN
  logic [15:0] checksum;
`endif
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_frame_loader_if #(.BUF_AW(BUF_AW)) bus ();

  sram_frame_loader #(
    .WORDS(WORDS), .BASE_ADDR(BASE_ADDR), .RD_WAIT(RD_WAIT), .BUF_AW(BUF_AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bus       (bus),
    .busy      (busy),
    .load_done (load_done),
`ifdef CHECKSUM_EN
    .checksum  (checksum),
`endif
    .state_dbg (state_dbg)
  );

  function automatic logic [15:0] io_of(input logic [19:0] a, input logic ck);
    if (ck) return (a == 20'd0) ? 16'hFFFF : ((a == 20'd1) ? 16'h0002 : 16'h0000);
    return 16'hA0B0 + a[15:0];
  endfunction

  assign bus.IO = io_of(bus.addr, ck_mode);

  // monitor
  strobe_t obs_q[$];
  logic    we_bad   = 1'b0;
  logic    pair_bad = 1'b0;

  always @(negedge clk) begin
    if (bus.WE_n !== 1'b1) we_bad = 1'b1;
    if (bus.w_en_b !== bus.w_en_a || bus.addr_b !== bus.addr_a) pair_bad = 1'b1;
    if (bus.w_en_a === 1'b1) obs_q.push_back('{cyc, bus.addr_a, bus.data_a, bus.data_b});
  end

  // scoreboard
  logic [EW-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_strobes(input int t, input int first, input int n);
    logic [EW-1:0] e;
    for (int i = 0; i < n; i++) exp_q.push_back({BUF_AW'(i), 8'hA0, 8'hB0 + 8'(i)});
    check("strobe_count", 64'(obs_q.size() - first), 64'(n));
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      if (first + i < obs_q.size()) begin
        check("strobe_data", {obs_q[first+i].a, obs_q[first+i].db, obs_q[first+i].da}, e);
        check("strobe_cycle", 64'(obs_q[first+i].cyc), 64'(t + 1 + P + i * P));
      end
    end
  endtask

  // driver tasks
  task automatic pulse_start(output int t);
    @(negedge clk) start = 1'b0;
    @(negedge clk) start = 1'b1;
    t = cyc;
  endtask

  task automatic wait_done(input int budget, output int seen);
    seen = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (load_done === 1'b1) begin
        seen = cyc;
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  initial begin
    int t, seen, first;

    // 1: reset values
    idle(2);
    check("rst_ce_n", bus.CE_n, 1);
    check("rst_oe_n", bus.OE_n, 1);
    check("rst_ub_lb", {bus.UB_n, bus.LB_n}, 2'b11);
    check("rst_we_n", bus.WE_n, 1);
    check("rst_addr", bus.addr, BASE_ADDR);
    check("rst_wen", {bus.w_en_a, bus.w_en_b}, 0);
    check("rst_addr_ab", {bus.addr_a, bus.addr_b}, 0);
    check("rst_data_ab", {bus.data_a, bus.data_b}, 0);
    check("rst_busy_done", {busy, load_done}, 0);
    check("rst_state", state_dbg, IDLE);
    rst = 1'b1;
    idle(2);

    // 2: basic load
    first = obs_q.size();
    pulse_start(t);
    check("trig_busy", busy, 1);
    check("trig_ce_n", bus.CE_n, 1);
    @(negedge clk);
    check("read_ce_n", {bus.CE_n, bus.OE_n, bus.UB_n, bus.LB_n}, 4'b0000);
    check("read_addr0", bus.addr, 0);
    idle(3);
    check("read_addr1", bus.addr, 1);
    check("read_ce_held", bus.CE_n, 0);
    wait_done(40, seen);
    check("done_time", 64'(seen), 64'(t + 2 + WORDS * P));
    check("done_busy", busy, 0);
    check("done_ce_n", bus.CE_n, 1);
    check("done_state", state_dbg, DONE);
    check_strobes(t, first, WORDS);

    // 3: second pulse mid-load ignored
    idle(2);
    first = obs_q.size();
    pulse_start(t);
    idle(4);
    @(negedge clk) start = 1'b0;
    @(negedge clk) start = 1'b1;
    wait_done(40, seen);
    check("retrig_done_time", 64'(seen), 64'(t + 2 + WORDS * P));
    idle(10);
    check_strobes(t, first, WORDS);

    // 4: start held low -> one load; release and pulse -> reload
    first = obs_q.size();
    @(negedge clk) start = 1'b0;
    @(negedge clk) t = cyc;
    idle(99);
    start = 1'b1;
    check("held_done", load_done, 1);
    check_strobes(t, first, WORDS);
    first = obs_q.size();
    pulse_start(t);
    check("reload_done_clr", {load_done, busy}, 2'b01);
    wait_done(40, seen);
    check("reload_done_time", 64'(seen), 64'(t + 2 + WORDS * P));
    check_strobes(t, first, WORDS);

    // 5: reset during word 2, then full restart
    idle(2);
    first = obs_q.size();
    pulse_start(t);
    idle(8);
    rst = 1'b0;
    #1;
    check("midrst_ce_n", bus.CE_n, 1);
    check("midrst_outs", {busy, load_done, bus.w_en_a}, 0);
    check("midrst_addr", bus.addr, BASE_ADDR);
    idle(2);
    rst = 1'b1;
    idle(6);
    check_strobes(t, first, 2);
    first = obs_q.size();
    pulse_start(t);
    wait_done(40, seen);
    check("restart_done_time", 64'(seen), 64'(t + 2 + WORDS * P));
    check_strobes(t, first, WORDS);

`ifdef CHECKSUM_EN
    // 6: checksum wraps modulo 2**16
    ck_mode = 1'b1;
    idle(2);
    pulse_start(t);
    wait_done(40, seen);
    check("ck_done_time", 64'(seen), 64'(t + 2 + WORDS * P));
    check("checksum", checksum, 16'h0001);
    ck_mode = 1'b0;
`endif

    check("we_n_const", we_bad, 0);
    check("bank_pair_eq", pair_bad, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
